// File: rtl/mux_scan_pkg.sv
// Shared constants and helpers for the mux_scan datapath block.
package mux_scan_pkg;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // Index width for n items, never narrower than one bit.
   function automatic int unsigned sel_width(input int unsigned n);
      if (n <= 2) begin
         return 1;
      end
      return $clog2(n);
   endfunction

endpackage

// File: rtl/mux_scan_dwell_counter.sv
// Dwell counter: counts enabled cycles modulo DWELL and flags the terminal count.
module mux_scan_dwell_counter
   import mux_scan_pkg::*;
#(
   parameter int unsigned DWELL = 4
) (
   input  logic clock_i,
   input  logic reset_i,
   input  logic clear_i,
   input  logic en_i,
   output logic tc_o
);

   localparam int unsigned CntW = sel_width(DWELL);

   logic [CntW-1:0] cnt_q;
   logic [CntW-1:0] cnt_d;

   // Terminal count only counts as such when the counter is actually advancing.
   always_comb begin
      tc_o = en_i && (cnt_q == CntW'(DWELL - 1));
   end

   // Next count: clear beats enable; wrap to zero at the terminal count.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = tc_o ? '0 : cnt_q + CntW'(1);
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mux_scan.sv
// Registered N-channel word multiplexer with manual select or timed auto-scan.
module mux_scan
   import mux_scan_pkg::*;
#(
   parameter  int unsigned WIDTH    = 1,
   parameter  int unsigned CHANNELS = 4,
   parameter  int unsigned DWELL    = 4,
   localparam int unsigned SELW     = sel_width(CHANNELS)
) (
   input  logic                      clock_i,
   input  logic                      reset_i,
   input  logic [CHANNELS*WIDTH-1:0] data_in_i,
   input  logic [SELW-1:0]           sel_i,
   input  logic                      mode_i,
   input  logic                      hold_i,
   output logic [WIDTH-1:0]          out_o,
   output logic [SELW-1:0]           chan_o,
   output logic                      valid_o
);

   logic [WIDTH-1:0] out_q, out_d;
   logic [SELW-1:0]  chan_q, chan_d;
   logic             valid_q, valid_d;

   logic             tc;
   logic             sel_legal;
   logic [SELW-1:0]  scan_base;
   logic [SELW-1:0]  scan_next;
   logic [WIDTH-1:0] word;

   // Dwell count is parked at zero in manual mode so a scan always starts fresh.
   mux_scan_dwell_counter #(
      .DWELL (DWELL)
   ) u_dwell (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .clear_i (mode_i == MODE_MANUAL),
      .en_i    (!hold_i),
      .tc_o    (tc)
   );

   // Channel selection: the scan channel register is chan_q itself, and an
   // out-of-range manual channel restarts the scan from zero.
   always_comb begin
      sel_legal = 32'(sel_i) < CHANNELS;
      scan_base = (32'(chan_q) < CHANNELS) ? chan_q : '0;
      scan_next = scan_base;
      if (tc) begin
         scan_next = (32'(scan_base) == CHANNELS - 1) ? '0 : scan_base + SELW'(1);
      end
      if (mode_i == MODE_SCAN) begin
         chan_d  = scan_next;
         valid_d = 1'b1;
      end else begin
         chan_d  = sel_i;
         valid_d = sel_legal;
      end
   end

   // N:1 word select on the next channel; illegal selections read as zero.
   always_comb begin
      word = '0;
      for (int k = 0; k < int'(CHANNELS); k++) begin
         if (chan_d == SELW'(k)) begin
            word = data_in_i[k*WIDTH +: WIDTH];
         end
      end
      out_d = valid_d ? word : '0;
   end

   // Output registers with synchronous reset.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         out_q   <= '0;
         chan_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         out_q   <= out_d;
         chan_q  <= chan_d;
         valid_q <= valid_d;
      end
   end

   assign out_o   = out_q;
   assign chan_o  = chan_q;
   assign valid_o = valid_q;

endmodule

// File: tb/tb_mux_scan.sv
// Directed self-checking bench for mux_scan (4- and 3-channel, DWELL 3 and 1).
module tb_mux_scan;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] data4;
   logic [1:0]  sel4;
   logic        mode;
   logic        hold;
   logic [11:0] data3;
   logic [1:0]  sel3;
   logic        mode3;

   logic [3:0]  out4, out3, out1;
   logic [1:0]  chan4, chan3, chan1;
   logic        valid4, valid3, valid1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mux_scan #(.WIDTH(4), .CHANNELS(4), .DWELL(3)) u_dut4 (
      .clock_i (clk), .reset_i (reset), .data_in_i (data4), .sel_i (sel4),
      .mode_i (mode), .hold_i (hold), .out_o (out4), .chan_o (chan4), .valid_o (valid4)
   );

   mux_scan #(.WIDTH(4), .CHANNELS(3), .DWELL(3)) u_dut3 (
      .clock_i (clk), .reset_i (reset), .data_in_i (data3), .sel_i (sel3),
      .mode_i (mode3), .hold_i (1'b0), .out_o (out3), .chan_o (chan3), .valid_o (valid3)
   );

   mux_scan #(.WIDTH(4), .CHANNELS(4), .DWELL(1)) u_dut1 (
      .clock_i (clk), .reset_i (reset), .data_in_i (data4), .sel_i (sel4),
      .mode_i (mode), .hold_i (hold), .out_o (out1), .chan_o (chan1), .valid_o (valid1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk4(input string tag, input logic [3:0] o, input logic [1:0] c,
                       input logic v, input logic [3:0] eo, input logic [1:0] ec,
                       input logic ev);
      chk({tag, ".out"}, 32'(o), 32'(eo));
      chk({tag, ".chan"}, 32'(c), 32'(ec));
      chk({tag, ".valid"}, 32'(v), 32'(ev));
   endtask

   int          scan_chan [12] = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
   logic [3:0]  scan_out  [12] = '{4'hA, 4'hA, 4'hB, 4'hB, 4'hB, 4'hC,
                                   4'hC, 4'hC, 4'hD, 4'hD, 4'hD, 4'hA};
   int          fast_chan [5]  = '{1, 2, 3, 0, 1};

   initial begin
      reset = 1'b1; mode = 1'b0; hold = 1'b0; sel4 = 2'd0; data4 = 16'hDCBA;
      sel3 = 2'd0; mode3 = 1'b0; data3 = 12'h321;

      // Reset held two cycles.
      tick(); tick();
      chk4("reset", out4, chan4, valid4, 4'h0, 2'd0, 1'b0);
      chk("reset3.valid", 32'(valid3), 32'd0);

      // Manual select on the 4-channel part, out-of-range on the 3-channel part.
      reset = 1'b0; sel4 = 2'd2; sel3 = 2'd3;
      tick();
      chk4("man_sel2", out4, chan4, valid4, 4'hC, 2'd2, 1'b1);
      chk4("oor_sel3", out3, chan3, valid3, 4'h0, 2'd3, 1'b0);
      sel4 = 2'd3; sel3 = 2'd1;
      tick();
      chk4("man_sel3", out4, chan4, valid4, 4'hD, 2'd3, 1'b1);
      chk4("oor_back", out3, chan3, valid3, 4'h2, 2'd1, 1'b1);

      // Scan entered from an out-of-range channel starts at zero.
      sel3 = 2'd3;
      tick();
      chk("oor_again.valid", 32'(valid3), 32'd0);
      mode3 = 1'b1;
      tick();
      chk4("oor_scan", out3, chan3, valid3, 4'h1, 2'd0, 1'b1);

      // Park on channel 0, then scan and wrap.
      sel4 = 2'd0;
      tick();
      chk4("man_sel0", out4, chan4, valid4, 4'hA, 2'd0, 1'b1);
      mode = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         chk($sformatf("scan[%0d].chan", i), 32'(chan4), 32'(scan_chan[i]));
         chk($sformatf("scan[%0d].out", i), 32'(out4), 32'(scan_out[i]));
         if (i < 5) begin
            chk($sformatf("dwell1[%0d].chan", i), 32'(chan1), 32'(fast_chan[i]));
         end
      end

      // Advance to channel 1 with dwell count 1.
      tick(); tick(); tick(); tick();
      chk4("pre_hold", out4, chan4, valid4, 4'hB, 2'd1, 1'b1);

      // Hold for 5 cycles; live data on the frozen channel changes mid-hold.
      hold = 1'b1;
      tick(); tick();
      chk4("hold2", out4, chan4, valid4, 4'hB, 2'd1, 1'b1);
      data4 = 16'hDC7A;
      tick();
      chk4("hold3", out4, chan4, valid4, 4'h7, 2'd1, 1'b1);
      tick(); tick();
      chk4("hold5", out4, chan4, valid4, 4'h7, 2'd1, 1'b1);
      hold = 1'b0;
      tick();
      chk4("release1", out4, chan4, valid4, 4'h7, 2'd1, 1'b1);
      tick();
      chk4("release2", out4, chan4, valid4, 4'hC, 2'd2, 1'b1);
      tick();
      chk("ch2_d1.chan", 32'(chan4), 32'd2);

      // Reset mid-scan at channel 2, dwell 1.
      reset = 1'b1;
      tick();
      chk4("mid_reset", out4, chan4, valid4, 4'h0, 2'd0, 1'b0);
      reset = 1'b0;
      tick();
      chk4("restart1", out4, chan4, valid4, 4'hA, 2'd0, 1'b1);
      tick();
      chk("restart2.chan", 32'(chan4), 32'd0);
      tick();
      chk4("restart3", out4, chan4, valid4, 4'h7, 2'd1, 1'b1);

      // Back to manual mid-dwell, then re-enter scan from channel 3 with fresh dwell.
      mode = 1'b0; sel4 = 2'd3;
      tick();
      chk4("to_manual", out4, chan4, valid4, 4'hD, 2'd3, 1'b1);
      mode = 1'b1;
      tick(); tick();
      chk("rescan2.chan", 32'(chan4), 32'd3);
      tick();
      chk4("rescan_wrap", out4, chan4, valid4, 4'hA, 2'd0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mux_scan.md
# mux_scan

Parametrised, registered N-channel, W-bit multiplexer for the lab datapath. It replaces the single-bit gate-level 2:1 mux. It selects one of CHANNELS input words either from a manual select (switches) or by automatically scanning the channels with a programmable dwell time. The registered output and current channel index feed LED/HEX display logic.

## Interface
- WIDTH, 1: bits per channel, ≥1.
- CHANNELS, 4: number of input channels, ≥2; any value, not only powers of two.
- DWELL, 4: clock cycles spent on each channel in scan mode, ≥1.
- SELW, derived: $clog2(CHANNELS); not overridable.

- clock  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset, sampled on the rising edge of clock.
- data_in  in  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- sel  in  SELW  manual channel select, used when mode=0.
- mode  in  1  0 = manual, 1 = scan.
- hold  in  1  scan mode only: freezes the dwell counter and channel index.
- out  out  WIDTH  registered selected word.
- chan  out  SELW  registered index of the channel currently driving out.
- valid  out  1  out/chan hold a legal selection.

## Operation
- Reset (reset=1 at an edge) sets out=0, chan=0, valid=0, dwell count=0. Reset overrides every other input.
- Manual mode (mode=0):
  - each edge: chan←sel; out←data_in[sel]; valid←1.
  - if sel ≥ CHANNELS: out←0, chan←sel, valid←0.
  - dwell count is held at 0.
- Scan mode (mode=1):
  - internal channel register c, dwell count d ∈ [0, DWELL-1].
  - each edge with hold=0: if d==DWELL-1 then d←0 and c←(c==CHANNELS-1 ? 0 : c+1); else d←d+1.
  - hold=1: c and d unchanged.
  - every edge, regardless of hold: out←data_in[next c]; chan←next c; valid←1. Live data on the frozen channel keeps updating.
- Mode 0→1 switch: scanning starts from the current chan with d=0. If chan was out of range, scanning starts at 0.
- Mode 1→0 switch: manual takes effect on that same edge; d←0.
- DWELL=1: channel advances every cycle.

## Timing
- Latency: one cycle from data_in/sel/mode change to out/chan/valid.
- No combinational path from any input to any output.
- Scan period: exactly DWELL×CHANNELS cycles per full sweep while hold=0.
- First edge after reset deasserts: valid←1 if the selection is legal.
- Reset asserted mid-scan: next edge gives out=0, chan=0, valid=0, d=0. The scan restarts from channel 0 after release.
- Wrap-around: after channel CHANNELS-1 dwells DWELL cycles, the next edge gives chan=0.
- hold and the dwell terminal count on the same edge: hold wins; no advance.

## Structure
- Shared package mux_scan_pkg:
  - localparam function for SELW ($clog2 with a minimum of 1).
  - mode constants MODE_MANUAL=1'b0, MODE_SCAN=1'b1.
- Sub-module dwell_counter (parameter DWELL; ports clock, reset, clear, en, tc):
  - tc is high when count==DWELL-1 and en=1.
  - clear has priority over en.
- Top level holds the channel register, the out-of-range check, and the registered N:1 word select.

## Test plan
- Reset: WIDTH=4, CHANNELS=4, data_in=16'hDCBA, reset=1 for 2 cycles → out=0, chan=0, valid=0.
- Manual select: mode=0, sel=2, then sel=3 one cycle later → out=4'hC, chan=2, then out=4'hD, chan=3, each one cycle after the change; valid=1 throughout.
- Out of range: CHANNELS=3, sel=3 → out=0, chan=3, valid=0. Then sel=1 → out=data_in ch1, valid=1.
- Scan and wrap: DWELL=3, mode=1 from chan=0 → chan sequence 0,0,0,1,1,1,2,2,2,3,3,3,0; out tracks each channel's word.
- Hold: hold=1 for 5 cycles while scanning on channel 1 at d=1; change ch1 data mid-hold → chan stays 1, out follows the new data. After release, 1 more cycle on ch1, then chan=2.
- Reset mid-scan: reset=1 while chan=2, d=1 → next edge out=0, chan=0, valid=0. After release, the scan restarts with a full DWELL on channel 0.
